// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: datapath width, NOP encoding, reset PC and fetch FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_FETCH  = 2'd0;
  localparam fetch_state_t ST_HOLD   = 2'd1;
  localparam fetch_state_t ST_SQUASH = 2'd2;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise holds; output one cycle after load.
// No backpressure of its own; the caller gates load/flush from stall and redirect.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] ld_instr,
  input  logic [XLEN-1:0] ld_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_n,
  output logic            valid
);

  // A flush leaves PC/PC_n untouched so a stalled bubble stays bit-exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= NOP_INSTR;
      pc    <= RESET_PC;
      pc_n  <= pc_plus4(RESET_PC);
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      instr <= ld_instr;
      pc    <= ld_pc;
      pc_n  <= pc_plus4(ld_pc);
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch FSM + IF/ID register: one-cycle fetch-to-IF/ID latency; stall parks a ready response in a
// one-entry buffer with imem_req dropped; redirect overrides stall and squashes in-flight fetches.
module if_id_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_n,
  output logic            valid
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] tgt, tgt_nxt;
  logic [XLEN-1:0] buf_instr;
  logic            buf_cap;
  logic            ifid_load, ifid_flush;
  logic [XLEN-1:0] ld_instr;

  // Moore outputs; the buffered PC is fetch_pc itself since it only advances on leaving HOLD.
  assign imem_req  = !reset && (state != ST_HOLD);
  assign imem_addr = fetch_pc;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    tgt_nxt      = tgt;
    buf_cap      = 1'b0;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ld_instr     = imem_rdata;
    case (state)
      ST_FETCH: begin
        if (redirect) begin
          ifid_flush = 1'b1;
          if (imem_ready) begin
            fetch_pc_nxt = redirect_pc;
          end else begin
            tgt_nxt   = redirect_pc;
            state_nxt = ST_SQUASH;
          end
        end else if (imem_ready) begin
          if (stall) begin
            buf_cap   = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            ifid_load    = 1'b1;
            fetch_pc_nxt = pc_plus4(fetch_pc);
          end
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          ifid_flush   = 1'b1;
          fetch_pc_nxt = redirect_pc;
          state_nxt    = ST_FETCH;
        end else if (!stall) begin
          ifid_load    = 1'b1;
          ld_instr     = buf_instr;
          fetch_pc_nxt = pc_plus4(fetch_pc);
          state_nxt    = ST_FETCH;
        end
      end
      ST_SQUASH: begin
        ifid_flush = 1'b1;
        if (redirect) tgt_nxt = redirect_pc;
        if (imem_ready) begin
          fetch_pc_nxt = redirect ? redirect_pc : tgt;
          state_nxt    = ST_FETCH;
        end
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_FETCH;
      fetch_pc  <= RESET_PC;
      tgt       <= RESET_PC;
      buf_instr <= NOP_INSTR;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      tgt      <= tgt_nxt;
      if (buf_cap) buf_instr <= imem_rdata;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR),
    .RESET_PC  (RESET_PC)
  ) u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .ld_instr (ld_instr),
    .ld_pc    (fetch_pc),
    .instr    (instr),
    .pc       (PC),
    .pc_n     (PC_n),
    .valid    (valid)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: transaction-level fetch model checked every cycle plus directed literal checks.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr, pc, pc_n;
  logic        valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0001_2083;
      32'h4: return 32'h0032_2023;
      32'h8: return 32'h0083_2283;
      default: return a ^ 32'h5A5A_0003;
    endcase
  endfunction

  assign imem_rdata = memword(imem_addr);

  if_id_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .PC          (pc),
    .PC_n        (pc_n),
    .valid       (valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: next fetch address, an optional parked instruction, an optional pending squash target.
  logic [31:0] m_pc, m_buf, m_tgt;
  bit          m_have_buf, m_squashing;
  logic [31:0] e_instr, e_pc, e_pcn;
  bit          e_valid;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 32'h0; m_have_buf = 0; m_squashing = 0; m_buf = NOP; m_tgt = 32'h0;
      e_instr = NOP; e_pc = 32'h0; e_pcn = 32'h4; e_valid = 0;
    end else if (redirect) begin
      e_instr = NOP; e_valid = 0;
      if (m_have_buf) begin
        m_have_buf = 0; m_pc = redirect_pc;
      end else if (m_squashing) begin
        if (imem_ready) begin m_squashing = 0; m_pc = redirect_pc; end
        else m_tgt = redirect_pc;
      end else if (imem_ready) begin
        m_pc = redirect_pc;
      end else begin
        m_squashing = 1; m_tgt = redirect_pc;
      end
    end else if (m_have_buf) begin
      if (!stall) begin
        e_instr = m_buf; e_pc = m_pc; e_pcn = m_pc + 32'd4; e_valid = 1;
        m_have_buf = 0; m_pc = m_pc + 32'd4;
      end
    end else if (m_squashing) begin
      e_instr = NOP; e_valid = 0;
      if (imem_ready) begin m_squashing = 0; m_pc = m_tgt; end
    end else if (imem_ready) begin
      if (stall) begin
        m_have_buf = 1; m_buf = memword(m_pc);
      end else begin
        e_instr = memword(m_pc); e_pc = m_pc; e_pcn = m_pc + 32'd4; e_valid = 1;
        m_pc = m_pc + 32'd4;
      end
    end else if (!stall) begin
      e_instr = NOP; e_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("instr", instr, e_instr);
      chk("PC", pc, e_pc);
      chk("PC_n", pc_n, e_pcn);
      chk("valid", {31'b0, valid}, {31'b0, e_valid});
      chk("imem_req", {31'b0, imem_req}, {31'b0, !m_have_buf});
      chk("imem_addr", imem_addr, m_pc);
    end
  end

  task automatic step(input bit s, input bit r, input logic [31:0] rp, input bit rd);
    stall = s; redirect = r; redirect_pc = rp; imem_ready = rd;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; stall = 0; redirect = 0; redirect_pc = 0; imem_ready = 1;
    #11;
    chk("rst instr", instr, NOP);
    chk("rst PC", pc, 32'h0);
    chk("rst PC_n", pc_n, 32'h4);
    chk("rst valid", {31'b0, valid}, 32'h0);
    chk("rst imem_req", {31'b0, imem_req}, 32'h0);
    #1 reset = 1'b0;

    // streaming
    step(0, 0, 0, 1);
    chk("s1 PC", pc, 32'h0);
    chk("s1 instr", instr, 32'h0001_2083);
    chk("s1 valid", {31'b0, valid}, 32'h1);
    step(0, 0, 0, 1);
    chk("s2 PC", pc, 32'h4);
    chk("s2 PC_n", pc_n, 32'h8);
    chk("s2 instr", instr, 32'h0032_2023);

    // stall three cycles with ready high
    step(1, 0, 0, 1);
    chk("hold req", {31'b0, imem_req}, 32'h0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("hold PC", pc, 32'h4);
    chk("hold instr", instr, 32'h0032_2023);
    step(0, 0, 0, 1);
    chk("unstall PC", pc, 32'h8);
    chk("unstall instr", instr, 32'h0083_2283);
    step(0, 0, 0, 1);
    chk("no skip PC", pc, 32'hC);

    // redirect with response ready
    step(0, 1, 32'h40, 1);
    chk("redir valid", {31'b0, valid}, 32'h0);
    chk("redir instr", instr, NOP);
    step(0, 0, 0, 1);
    chk("redir tgt PC", pc, 32'h40);
    chk("redir tgt instr", instr, 32'h5A5A_0043);

    // redirect with response pending
    step(0, 1, 32'h80, 0);
    chk("sq addr0", imem_addr, 32'h44);
    step(0, 0, 0, 0);
    chk("sq addr1", imem_addr, 32'h44);
    chk("sq valid", {31'b0, valid}, 32'h0);
    step(0, 0, 0, 1);
    chk("sq valid2", {31'b0, valid}, 32'h0);
    chk("sq new addr", imem_addr, 32'h80);
    step(0, 0, 0, 1);
    chk("sq tgt PC", pc, 32'h80);

    // stall and redirect together, in FETCH then in HOLD
    step(1, 1, 32'h20, 1);
    chk("sr valid", {31'b0, valid}, 32'h0);
    chk("sr addr", imem_addr, 32'h20);
    step(1, 0, 0, 1);
    step(1, 1, 32'h30, 0);
    chk("hr addr", imem_addr, 32'h30);
    chk("hr req", {31'b0, imem_req}, 32'h1);
    step(0, 0, 0, 1);
    chk("hr PC", pc, 32'h30);

    // a second redirect during SQUASH replaces the target
    step(0, 1, 32'h100, 0);
    step(0, 1, 32'h200, 0);
    step(0, 0, 0, 1);
    chk("sq2 addr", imem_addr, 32'h200);

    // wrap-around
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    chk("wrap PC", pc, 32'hFFFF_FFFC);
    chk("wrap PC_n", pc_n, 32'h0);
    chk("wrap addr", imem_addr, 32'h0);

    // async reset in SQUASH
    step(0, 1, 32'h60, 0);
    #1 reset = 1'b1;
    imem_ready = 1'b1;
    #1;
    chk("arst instr", instr, NOP);
    chk("arst PC", pc, 32'h0);
    chk("arst PC_n", pc_n, 32'h4);
    chk("arst valid", {31'b0, valid}, 32'h0);
    chk("arst req", {31'b0, imem_req}, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    step(0, 0, 0, 1);
    chk("post rst PC", pc, 32'h0);
    chk("post rst instr", instr, 32'h0001_2083);

    // mixed traffic checked by the model
    for (int i = 0; i < 60; i++)
      step(i % 5 == 2, i % 7 == 3, 32'(i * 16), i % 3 != 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
